// File: rtl/st_split3_pkg.sv
// Shared constants for the three-way byte splitter: lane width, channel count
// and the byte-lane position of each channel inside the 24-bit sink word.
package st_split3_pkg;
  localparam int DATA_W        = 8;
  localparam int NUM_CH        = 3;
  localparam int DEPTH_DEFAULT = 4;
  localparam int IN_W          = DATA_W * NUM_CH;

  localparam int CH0_LO = 0;
  localparam int CH1_LO = 8;
  localparam int CH2_LO = 16;

  function automatic int lane_lo(input int ch);
    case (ch)
      0:       return CH0_LO;
      1:       return CH1_LO;
      default: return CH2_LO;
    endcase
  endfunction
endpackage

// File: rtl/st_split3_fifo.sv
// First-word-fall-through FIFO: head shows the oldest entry, or zero when empty.
// Storage is not reset; only pointers and occupancy are.
module st_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     occ;
  logic              do_push;
  logic              do_pop;

  assign full    = (occ == CW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/st_split3.sv
// Splits each 24-bit Avalon-ST beat into three independently drained byte streams.
// Input readiness depends only on registered FIFO fullness and reset.
module st_split3
  import st_split3_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic [IN_W-1:0]   asi_in_data,
  input  logic              asi_in_valid,
  output logic              asi_in_ready,
  output logic [DATA_W-1:0] aso_out0_data,
  output logic [DATA_W-1:0] aso_out1_data,
  output logic [DATA_W-1:0] aso_out2_data,
  output logic              aso_out0_valid,
  output logic              aso_out1_valid,
  output logic              aso_out2_valid,
  input  logic              aso_out0_ready,
  input  logic              aso_out1_ready,
  input  logic              aso_out2_ready,
  output logic [15:0]       coe_count,
  output logic              coe_busy
);
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] out_ready;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] head [NUM_CH];
  logic              accept;
  logic [15:0]       count;

  assign out_ready    = {aso_out2_ready, aso_out1_ready, aso_out0_ready};
  assign asi_in_ready = !rsi_reset && (full == '0);
  assign accept       = asi_in_valid && asi_in_ready;
  assign pop          = out_ready & ~empty;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    st_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (csi_clk),
      .rst   (rsi_reset),
      .push  (accept),
      .pop   (pop[ch]),
      .din   (asi_in_data[lane_lo(ch) +: DATA_W]),
      .head  (head[ch]),
      .full  (full[ch]),
      .empty (empty[ch])
    );
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset)   count <= '0;
    else if (accept) count <= count + 16'd1;
  end

  assign coe_count      = count;
  assign coe_busy       = |(~empty);
  assign aso_out0_valid = !empty[0];
  assign aso_out1_valid = !empty[1];
  assign aso_out2_valid = !empty[2];
  assign aso_out0_data  = head[0];
  assign aso_out1_data  = head[1];
  assign aso_out2_data  = head[2];
endmodule

// File: tb/tb_st_split3.sv
// Bench for st_split3: directed vector table, handshake corner sequences,
// and a cycle-level queue model compared against every output each cycle.
module tb_st_split3;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out0_data, out1_data, out2_data;
  logic        out0_valid, out1_valid, out2_valid;
  logic [2:0]  ordy;
  logic [15:0] count;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mq0[$];
  logic [7:0]  mq1[$];
  logic [7:0]  mq2[$];
  logic [15:0] mcnt = 16'd0;
  logic [7:0]  got0[$];
  logic [7:0]  got1[$];

  st_split3 #(.DEPTH(DEPTH)) dut (
    .csi_clk        (clk),
    .rsi_reset      (rst),
    .asi_in_data    (in_data),
    .asi_in_valid   (in_valid),
    .asi_in_ready   (in_ready),
    .aso_out0_data  (out0_data),
    .aso_out1_data  (out1_data),
    .aso_out2_data  (out2_data),
    .aso_out0_valid (out0_valid),
    .aso_out1_valid (out1_valid),
    .aso_out2_valid (out2_valid),
    .aso_out0_ready (ordy[0]),
    .aso_out1_ready (ordy[1]),
    .aso_out2_ready (ordy[2]),
    .coe_count      (count),
    .coe_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out0_valid && ordy[0]) got0.push_back(out0_data);
    if (!rst && out1_valid && ordy[1]) got1.push_back(out1_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic mready();
    return !rst && (mq0.size() < DEPTH) && (mq1.size() < DEPTH) && (mq2.size() < DEPTH);
  endfunction

  task automatic model_check();
    logic [2:0]  ev;
    logic [23:0] eh;
    ev = {mq2.size() != 0, mq1.size() != 0, mq0.size() != 0};
    eh = {ev[2] ? mq2[0] : 8'h00, ev[1] ? mq1[0] : 8'h00, ev[0] ? mq0[0] : 8'h00};
    chk("m_ready", in_ready, mready());
    chk("m_valid", {out2_valid, out1_valid, out0_valid}, ev);
    chk("m_data",  {out2_data, out1_data, out0_data}, eh);
    chk("m_count", count, mcnt);
    chk("m_busy",  busy, |ev);
  endtask

  task automatic model_update();
    logic acc;
    acc = in_valid && mready();
    if (rst) begin
      mq0.delete(); mq1.delete(); mq2.delete();
      mcnt = 16'd0;
    end else begin
      if (ordy[0] && mq0.size() != 0) void'(mq0.pop_front());
      if (ordy[1] && mq1.size() != 0) void'(mq1.pop_front());
      if (ordy[2] && mq2.size() != 0) void'(mq2.pop_front());
      if (acc) begin
        mq0.push_back(in_data[7:0]);
        mq1.push_back(in_data[15:8]);
        mq2.push_back(in_data[23:16]);
        mcnt = mcnt + 16'd1;
      end
    end
  endtask

  // Caller drives inputs just after a falling edge, then calls tick.
  task automatic tick();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic        v;
    logic [23:0] d;
    logic [2:0]  ordy;
    logic        e_rdy;
    logic [2:0]  e_vld;
    logic [23:0] e_head;
    logic [15:0] e_cnt;
    logic        e_busy;
  } vec_t;

  vec_t tbl[24];

  initial begin
    int stalls;
    int waited;
    logic er;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; ordy = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);

    tbl[0]  = '{1'b1, 1'b0, 24'h000000, 3'b111, 1'b0, 3'b000, 24'h000000, 16'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 24'h0C0B0A, 3'b111, 1'b1, 3'b000, 24'h000000, 16'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 24'h000000, 3'b111, 1'b1, 3'b111, 24'h0C0B0A, 16'd1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 24'h000000, 3'b111, 1'b1, 3'b000, 24'h000000, 16'd1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 24'h000000, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 24'h111111, 3'b000, 1'b1, 3'b000, 24'h000000, 16'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 24'h222222, 3'b000, 1'b1, 3'b111, 24'h111111, 16'd1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 24'h333333, 3'b000, 1'b1, 3'b111, 24'h111111, 16'd2, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 24'h444444, 3'b000, 1'b1, 3'b111, 24'h111111, 16'd3, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 24'h555555, 3'b000, 1'b0, 3'b111, 24'h111111, 16'd4, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 24'h555555, 3'b000, 1'b0, 3'b111, 24'h111111, 16'd4, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 24'h555555, 3'b111, 1'b0, 3'b111, 24'h111111, 16'd4, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 24'h555555, 3'b000, 1'b1, 3'b111, 24'h222222, 16'd4, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 24'h000000, 3'b111, 1'b0, 3'b111, 24'h222222, 16'd5, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 24'h000000, 3'b111, 1'b1, 3'b111, 24'h333333, 16'd5, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 24'h000000, 3'b111, 1'b1, 3'b111, 24'h444444, 16'd5, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 24'h000000, 3'b111, 1'b1, 3'b111, 24'h555555, 16'd5, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 24'h000000, 3'b111, 1'b1, 3'b000, 24'h000000, 16'd5, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 24'h030201, 3'b000, 1'b1, 3'b000, 24'h000000, 16'd5, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 24'h030201, 3'b000, 1'b1, 3'b111, 24'h030201, 16'd6, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 24'h030201, 3'b000, 1'b1, 3'b111, 24'h030201, 16'd7, 1'b1};
    tbl[21] = '{1'b1, 1'b1, 24'h030201, 3'b000, 1'b0, 3'b111, 24'h030201, 16'd8, 1'b1};
    tbl[22] = '{1'b1, 1'b0, 24'h000000, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 24'h000000, 3'b000, 1'b1, 3'b000, 24'h000000, 16'd0, 1'b0};

    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].v; in_data = tbl[i].d; ordy = tbl[i].ordy;
      #1;
      chk($sformatf("t%0d_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("t%0d_valid", i), {out2_valid, out1_valid, out0_valid}, tbl[i].e_vld);
      chk($sformatf("t%0d_data", i),  {out2_data, out1_data, out0_data}, tbl[i].e_head);
      chk($sformatf("t%0d_count", i), count, tbl[i].e_cnt);
      chk($sformatf("t%0d_busy", i),  busy, tbl[i].e_busy);
      tick();
    end

    // Channel 1 stalled while streaming 8 beats; released after the input backs up.
    got0.delete(); got1.delete();
    ordy = 3'b101;
    stalls = 0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = {3{8'(i)}};
      waited = 0;
      forever begin
        er = mready();
        if (!er) begin
          stalls++;
          if (stalls >= 3) ordy = 3'b111;
        end
        tick();
        if (er) break;
        waited++;
        if (waited > 50) begin
          chk("stall_timeout", waited, 0);
          break;
        end
      end
    end
    in_valid = 1'b0;
    ordy = 3'b111;
    repeat (8) tick();
    chk("stall_seen", stalls >= 3, 1);
    chk("ch1_len", got1.size(), 8);
    chk("ch0_len", got0.size(), 8);
    for (int k = 0; k < 8 && k < got1.size() && k < got0.size(); k++) begin
      chk($sformatf("ch1_byte%0d", k), got1[k], k + 1);
      chk($sformatf("ch0_byte%0d", k), got0[k], k + 1);
    end

    // Randomized valid/ready traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 24'($urandom);
      ordy     = 3'($urandom_range(0, 7));
      tick();
    end

    // Counter wrap: 65537 accepted beats after reset.
    rst = 1'b1; in_valid = 1'b0; ordy = 3'b111;
    tick();
    rst = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 24'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #1 chk("wrap_count", count, 16'd1);
    tick();
    #1 chk("wrap_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
